// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_responder
// Description : Line-granular main-memory model answering the cache's
//               rd_req/wr_req/gnt refill and write-back port. One whole line
//               is read or written per request; a one-cycle gnt pulse follows
//               a fixed programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_responder #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int RD_LATENCY    = 8,
    parameter int WR_LATENCY    = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ADDR_LEN-1:0]                 addr,
    input  logic                                rd_req,
    input  logic                                wr_req,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    rd_line,
    output logic                                gnt
);

    localparam int c_line_size = 2 ** LINE_ADDR_LEN;
    localparam int c_line_w    = 32 * c_line_size;
    localparam int c_depth     = 2 ** ADDR_LEN;
    localparam int c_max_lat   = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int c_cnt_w     = $clog2(c_max_lat + 1);

    localparam logic [c_cnt_w-1:0] c_rd_cnt = c_cnt_w'(RD_LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_wr_cnt = c_cnt_w'(WR_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [ADDR_LEN-1:0]    r_addr;
    logic                   r_is_wr;
    logic [c_line_w-1:0]    r_wline;
    logic                   r_gnt;
    logic [c_line_w-1:0]    r_rd_line;

    // Storage holds data XOR the address pattern, so the all-zero power-up
    // state of the array reads back as the {line, word} pattern.
    logic [c_line_w-1:0]    r_mem [c_depth];

    logic                   w_accept_wr;
    logic                   w_accept_rd;
    logic                   w_enter_resp;
    logic                   w_cm_wr;
    logic [ADDR_LEN-1:0]    w_cm_addr;
    logic [c_line_w-1:0]    w_cm_line;

    // Power-up content of a line: word w of line a is {a, w} zero-extended.
    function automatic logic [c_line_w-1:0] f_pattern(input logic [ADDR_LEN-1:0] a);
        logic [c_line_w-1:0] p;
        logic [LINE_ADDR_LEN-1:0] wi;
        p = '0;
        for (int w = 0; w < c_line_size; w++) begin
            wi = LINE_ADDR_LEN'(w);
            p[32*w +: 32] = 32'({a, wi});
        end
        return p;
    endfunction

    // Write wins over read when both are requested in IDLE.
    assign w_accept_wr = (r_state == IDLE) && wr_req;
    assign w_accept_rd = (r_state == IDLE) && !wr_req && rd_req;

    // Next-state, counter and commit selection; a latency of 1 commits
    // straight from IDLE using the live inputs instead of the latches.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        w_cm_wr      = r_is_wr;
        w_cm_addr    = r_addr;
        w_cm_line    = r_wline;
        case (r_state)
            IDLE: begin
                if (w_accept_wr) begin
                    w_cm_wr      = 1'b1;
                    w_cm_addr    = addr;
                    w_cm_line    = wr_line;
                    w_cnt_nxt    = c_wr_cnt;
                    w_enter_resp = (WR_LATENCY <= 1);
                    w_state_nxt  = (WR_LATENCY > 1) ? BUSY : RESP;
                end else if (w_accept_rd) begin
                    w_cm_wr      = 1'b0;
                    w_cm_addr    = addr;
                    w_cnt_nxt    = c_rd_cnt;
                    w_enter_resp = (RD_LATENCY <= 1);
                    w_state_nxt  = (RD_LATENCY > 1) ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, request latches, grant and read line; the array itself is only
    // written outside reset and is never cleared by it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_is_wr   <= 1'b0;
            r_wline   <= '0;
            r_gnt     <= 1'b0;
            r_rd_line <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_enter_resp;
            if (w_accept_wr || w_accept_rd) begin
                r_addr  <= addr;
                r_is_wr <= w_accept_wr;
            end
            if (w_accept_wr) begin
                r_wline <= wr_line;
            end
            if (w_enter_resp && !w_cm_wr) begin
                r_rd_line <= r_mem[w_cm_addr] ^ f_pattern(w_cm_addr);
            end
            if (w_enter_resp && w_cm_wr) begin
                r_mem[w_cm_addr] <= w_cm_line ^ f_pattern(w_cm_addr);
            end
        end
    end

    assign rd_line = r_rd_line;
    assign gnt     = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_mem_responder
// Description : Scoreboard bench for line_mem_responder: directed scenarios
//               plus randomized line traffic against a line-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;

    localparam int RD_LAT = 8;
    localparam int WR_LAT = 3;
    localparam int LAW    = 3;
    localparam int AW     = 9;
    localparam int LS     = 8;
    localparam int LW     = 32 * LS;
    localparam int DEPTH  = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          rd_req = 1'b0;
    logic          wr_req = 1'b0;
    logic [LW-1:0] wr_line = '0;
    logic [LW-1:0] rd_line;
    logic          gnt;

    line_mem_responder #(
        .LINE_ADDR_LEN (LAW),
        .ADDR_LEN      (AW),
        .RD_LATENCY    (RD_LAT),
        .WR_LATENCY    (WR_LAT)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .wr_line (wr_line),
        .rd_line (rd_line),
        .gnt     (gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_wr;
        int            edge_no;
        logic [LW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [LW-1:0] model_mem [DEPTH];
    logic [LW-1:0] model_rd = '0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            next_ok = 0;

    // Edge counter: at the falling edge after rising edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] pat(input int a);
        logic [LW-1:0] r;
        for (int w = 0; w < LS; w++) r[32*w +: 32] = 32'(a * LS + w);
        return r;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int w = 0; w < LS; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every gnt and tracks rd_line holding.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (gnt) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_gnt @edge %0d: got gnt=1 expected gnt=0", cyc);
                end else begin
                    e = q.pop_front();
                    check("gnt_edge", LW'(cyc), LW'(e.edge_no));
                    if (!e.is_wr) model_rd = e.data;
                end
            end else if (q.size() > 0 && cyc >= q[0].edge_no) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_gnt @edge %0d: got gnt=0 expected gnt=1 at edge %0d", cyc, q[0].edge_no);
                void'(q.pop_front());
            end
            check("rd_line", rd_line, model_rd);
        end
    end

    // Issue one transaction at the first legal edge; request held for hold edges.
    task automatic issue(input bit is_wr, input int a, input logic [LW-1:0] line, input int hold);
        exp_t e;
        int   k;
        int   lat;
        while (cyc + 1 < next_ok) @(negedge clk);
        addr    = AW'(a);
        wr_line = line;
        wr_req  = is_wr;
        rd_req  = !is_wr;
        k       = cyc + 1;
        lat     = is_wr ? WR_LAT : RD_LAT;
        e.is_wr   = is_wr;
        e.edge_no = k + lat;
        e.data    = is_wr ? '0 : model_mem[a];
        q.push_back(e);
        if (is_wr) model_mem[a] = line;
        next_ok = k + lat + 2;
        repeat (hold) @(negedge clk);
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        addr    = AW'($urandom);
        wr_line = rand_line();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() > 0 || cyc + 1 < next_ok) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout @edge %0d: got %0d pending expected 0 pending", cyc, q.size());
            q.delete();
        end
    endtask

    initial begin
        exp_t          e;
        int            k;
        int            a;
        bit            wr;
        logic [LW-1:0] line;
        logic [31:0]   word;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = pat(i);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_gnt", LW'(gnt), '0);
        check("reset_rd_line", rd_line, '0);
        rst_n   = 1'b1;
        next_ok = cyc + 1;

        // Read of the power-up pattern
        issue(1'b0, 5, '0, 1);
        wait_idle();
        word = rd_line[31:0];
        check("pattern_w0", LW'(word), LW'(32'h28));
        word = rd_line[255:224];
        check("pattern_w7", LW'(word), LW'(32'h2f));

        // Write then read, neighbour still pattern
        for (int w = 0; w < LS; w++) line[32*w +: 32] = 32'hA000_0000 + 32'(w);
        issue(1'b1, 'h1FF, line, 1);
        issue(1'b0, 'h1FF, '0, 1);
        issue(1'b0, 'h1FE, '0, 1);
        wait_idle();

        // Write-back immediately followed by refill
        issue(1'b1, 'h010, rand_line(), 1);
        issue(1'b0, 'h011, '0, 1);
        issue(1'b0, 'h010, '0, 1);
        wait_idle();

        // Simultaneous read and write: write first, read held until accepted
        line    = rand_line();
        addr    = AW'('h20);
        wr_line = line;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        k       = cyc + 1;
        e.is_wr = 1'b1; e.edge_no = k + WR_LAT; e.data = '0;
        q.push_back(e);
        model_mem['h20] = line;
        e.is_wr = 1'b0; e.edge_no = k + WR_LAT + 2 + RD_LAT; e.data = line;
        q.push_back(e);
        next_ok = k + WR_LAT + 2 + RD_LAT + 2;
        @(negedge clk);
        wr_req = 1'b0;
        while (cyc < k + WR_LAT + 2) @(negedge clk);
        rd_req = 1'b0;
        wait_idle();

        // Request dropped partway through BUSY
        issue(1'b0, 'h1FF, '0, 3);
        wait_idle();

        // Reset during a write aborts it
        addr    = AW'('h33);
        wr_line = rand_line();
        wr_req  = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        q.delete();
        model_rd = '0;
        #1;
        check("async_reset_gnt", LW'(gnt), '0);
        check("async_reset_rd_line", rd_line, '0);
        repeat (4) @(negedge clk);
        check("in_reset_gnt", LW'(gnt), '0);
        rst_n   = 1'b1;
        next_ok = cyc + 1;
        issue(1'b0, 'h33, '0, 1);
        wait_idle();

        // Randomized traffic over a small address window
        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = 'h40 + $urandom_range(0, 7);
            line = rand_line();
            issue(wr, a, line, $urandom_range(1, (wr ? WR_LAT : RD_LAT) + 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
